// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin I/D cache line-burst arbiter for a shared synchronous SRAM
module mem_arbiter #(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 32,
    parameter int LINE_WORDS = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_req,
    input  logic [ADDR_W-1:0]             i_addr,
    output logic [DATA_W-1:0]             i_rd_data,
    output logic                          i_rd_valid,
    output logic [$clog2(LINE_WORDS)-1:0] i_rd_idx,
    output logic                          i_done,
    input  logic                          d_req,
    input  logic                          d_we,
    input  logic [ADDR_W-1:0]             d_addr,
    input  logic [DATA_W-1:0]             d_wr_data,
    output logic [$clog2(LINE_WORDS)-1:0] d_wr_idx,
    output logic [DATA_W-1:0]             d_rd_data,
    output logic                          d_rd_valid,
    output logic [$clog2(LINE_WORDS)-1:0] d_rd_idx,
    output logic                          d_done,
    output logic                          busy,
    output logic [ADDR_W-1:0]             rdaddress,
    output logic                          rden,
    output logic [ADDR_W-1:0]             wraddress,
    output logic                          wren,
    output logic [DATA_W-1:0]             write_data,
    input  logic [DATA_W-1:0]             read_data
);
    localparam int IW = $clog2(LINE_WORDS);
    localparam int OW = IW + 2;
    localparam logic [IW-1:0] KLAST = IW'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0] LMASK = {{(ADDR_W-OW){1'b1}}, {OW{1'b0}}};
    typedef enum logic [1:0] {IDLE, RD_BURST, RD_DRAIN, WR_BURST} state_t;
    state_t state, state_nx;
    logic owner, last_grant, inflight, go, grant_d, rd, wr;
    logic [IW-1:0] k, inflight_idx;
    logic [ADDR_W-1:0] base, beat_addr;
    assign go        = i_req | d_req;
    // owner/last_grant encode 1 = D side; on a tie the side not granted last wins
    assign grant_d   = d_req & (!i_req | !last_grant);
    assign beat_addr = base + ADDR_W'({k, 2'b00});
    assign rd        = state == RD_BURST;
    assign wr        = state == WR_BURST;
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     state_nx = go ? ((grant_d && d_we) ? WR_BURST : RD_BURST) : IDLE;
            RD_BURST: state_nx = (k == KLAST) ? RD_DRAIN : RD_BURST;
            RD_DRAIN: state_nx = IDLE;
            WR_BURST: state_nx = (k == KLAST) ? IDLE : WR_BURST;
            default:  state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            k            <= '0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
            base         <= '0;
            inflight     <= 1'b0;
            inflight_idx <= '0;
        end else begin
            state        <= state_nx;
            inflight     <= rd;
            inflight_idx <= k;
            k            <= (state == IDLE) ? '0 : k + 1'b1;
            if (state == IDLE && go) begin
                owner      <= grant_d;
                last_grant <= grant_d;
                base       <= (grant_d ? d_addr : i_addr) & LMASK;
            end
        end
    end
    assign busy       = state != IDLE;
    assign rden       = rd;
    assign rdaddress  = rd ? beat_addr : '0;
    assign wren       = wr;
    assign wraddress  = wr ? beat_addr : '0;
    assign d_wr_idx   = wr ? k : '0;
    assign write_data = wr ? d_wr_data : '0;
    assign i_rd_valid = inflight & !owner;
    assign d_rd_valid = inflight & owner;
    assign i_rd_data  = i_rd_valid ? read_data : '0;
    assign d_rd_data  = d_rd_valid ? read_data : '0;
    assign i_rd_idx   = i_rd_valid ? inflight_idx : '0;
    assign d_rd_idx   = d_rd_valid ? inflight_idx : '0;
    assign i_done     = (state == RD_DRAIN) & !owner;
    assign d_done     = ((state == RD_DRAIN) & owner) | (wr & (k == KLAST));
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed + random checks of mem_arbiter against a burst-timeline model with shadow memory
module tb_mem_arbiter;
    localparam int AW = 16, DW = 32, LW = 4, IW = 2;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] i_addr = '0, d_addr = '0;
    logic [DW-1:0] i_rd_data, d_rd_data, d_wr_data, write_data;
    logic [DW-1:0] read_data = '0;
    logic [DW-1:0] wr_base = '0;
    logic i_rd_valid, d_rd_valid, i_done, d_done, busy, rden, wren;
    logic [IW-1:0] i_rd_idx, d_rd_idx, d_wr_idx;
    logic [AW-1:0] rdaddress, wraddress;
    logic [DW-1:0] sram [16384];
    logic [DW-1:0] shadow [16384];

    always #5 clk = ~clk;

    // D-cache writeback source: word = per-request base pattern + index
    assign d_wr_data = wr_base + 32'(d_wr_idx);

    always @(posedge clk) begin
        if (rden) read_data <= sram[rdaddress[15:2]];
        if (wren) sram[wraddress[15:2]] <= write_data;
    end

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LINE_WORDS(LW)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_rd_data(i_rd_data), .i_rd_valid(i_rd_valid),
        .i_rd_idx(i_rd_idx), .i_done(i_done),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wr_data(d_wr_data), .d_wr_idx(d_wr_idx),
        .d_rd_data(d_rd_data), .d_rd_valid(d_rd_valid), .d_rd_idx(d_rd_idx), .d_done(d_done),
        .busy(busy), .rdaddress(rdaddress), .rden(rden), .wraddress(wraddress), .wren(wren),
        .write_data(write_data), .read_data(read_data)
    );

    int total = 0, bad = 0, cyc = 0, t0 = 0;
    bit act = 0, side = 0, we = 0, lg = 1, scr = 0;
    bit pend [2] = '{0, 0};
    bit cool [2] = '{0, 0};
    int prob [2] = '{0, 0};
    logic [AW-1:0] base = '0;
    logic [DW-1:0] wb_cur = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s cycle %0d: got %h want %h", tag, cyc, obs, exp);
        end
    endtask

    task automatic new_req(input int s, input logic [AW-1:0] a, input bit w, input logic [DW-1:0] wb);
        pend[s] = 1;
        if (s == 0) i_addr = a;
        else begin
            d_addr  = a;
            d_we    = w;
            wr_base = wb;
        end
    endtask

    // One clock: check this cycle's outputs against the grant timeline, then drive the next edge
    task automatic cycle(input bit do_rst);
        int o, len;
        bit idle_now, e_rd, e_wr, e_val, e_done;
        logic [AW-1:0] ea, ra;
        logic [DW-1:0] ed;
        @(negedge clk);
        cyc++;
        if (scr) begin
            if (side) begin d_addr = 16'($urandom); d_we = 1'($urandom); end
            else i_addr = 16'($urandom);
            scr = 0;
        end
        o        = cyc - t0;
        len      = we ? LW : LW + 1;
        idle_now = !act;
        e_rd     = act && !we && o <= LW;
        e_wr     = act && we && o <= LW;
        e_val    = act && !we && o >= 2 && o <= LW + 1;
        e_done   = act && o == len;
        ea       = base + 16'(4 * (o - 1));
        ra       = base + 16'(4 * (o - 2));
        chk("busy", busy, act);
        chk("rden", rden, e_rd);
        chk("rdaddress", rdaddress, e_rd ? ea : 16'h0);
        chk("wren", wren, e_wr);
        chk("wraddress", wraddress, e_wr ? ea : 16'h0);
        chk("write_data", write_data, e_wr ? wb_cur + 32'(o - 1) : 32'h0);
        chk("d_wr_idx", d_wr_idx, e_wr ? 32'(o - 1) : 32'h0);
        chk("i_rd_valid", i_rd_valid, e_val && !side);
        chk("d_rd_valid", d_rd_valid, e_val && side);
        chk("i_done", i_done, e_done && !side);
        chk("d_done", d_done, e_done && side);
        if (e_val) begin
            ed = shadow[ra[15:2]];
            if (side) begin
                chk("d_rd_idx", d_rd_idx, 32'(o - 2));
                chk("d_rd_data", d_rd_data, ed);
            end else begin
                chk("i_rd_idx", i_rd_idx, 32'(o - 2));
                chk("i_rd_data", i_rd_data, ed);
            end
        end
        if (e_wr) shadow[ea[15:2]] = wb_cur + 32'(o - 1);
        for (int s = 0; s < 2; s++) begin
            if (cool[s]) cool[s] = 0;
            else if (!pend[s] && $urandom_range(0, 99) < prob[s])
                new_req(s, 16'($urandom), 1'($urandom), $urandom);
        end
        if (e_done) begin
            act        = 0;
            pend[side] = 0;
            cool[side] = 1;
        end else if (idle_now && !do_rst && (pend[0] || pend[1])) begin
            side   = (pend[0] && pend[1]) ? !lg : pend[1];
            lg     = side;
            act    = 1;
            t0     = cyc;
            we     = side ? d_we : 1'b0;
            base   = (side ? d_addr : i_addr) & 16'hFFF0;
            wb_cur = wr_base;
            scr    = 1;
        end
        if (do_rst) begin
            act  = 0;
            scr  = 0;
            lg   = 1;
            pend = '{0, 0};
            cool = '{0, 0};
        end
        i_req = pend[0];
        d_req = pend[1];
        rst   = do_rst;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            sram[i]   = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
            shadow[i] = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
        end
        cycle(1);
        cycle(1);
        // I fill of the 0400 line
        new_req(0, 16'h0407, 0, 0);
        repeat (8) cycle(0);
        // D writeback of the 1000 line
        new_req(1, 16'h1000, 1, 32'h2222_0000);
        repeat (7) cycle(0);
        // simultaneous requests, twice
        new_req(0, 16'h2040, 0, 0);
        new_req(1, 16'h3000, 0, 0);
        repeat (16) cycle(0);
        new_req(0, 16'h2080, 0, 0);
        new_req(1, 16'h3010, 1, 32'hBEEF_0000);
        repeat (16) cycle(0);
        // D re-raises immediately while I is held
        prob[1] = 100;
        new_req(1, 16'h4000, 1, 32'hA000_0000);
        cycle(0);
        new_req(0, 16'h5000, 0, 0);
        repeat (20) cycle(0);
        prob[1] = 0;
        repeat (12) cycle(0);
        // reset during beat 2 of an I fill, then a normal D fill
        new_req(0, 16'h6000, 0, 0);
        repeat (3) cycle(0);
        cycle(1);
        new_req(1, 16'h7000, 0, 0);
        repeat (10) cycle(0);
        // top-of-memory lines
        new_req(1, 16'hFFF0, 0, 0);
        repeat (8) cycle(0);
        new_req(1, 16'hFFFC, 1, 32'h5555_0000);
        repeat (7) cycle(0);
        new_req(0, 16'hFFF0, 0, 0);
        repeat (8) cycle(0);
        // random traffic
        prob = '{30, 30};
        repeat (600) cycle(0);
        prob = '{0, 0};
        repeat (20) cycle(0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
